// File: rtl/prog_range_match_tree.sv
// prog_range_match_tree: runtime-programmable pipelined binary-search range
// matcher. A KEY_W-bit key walks a DEPTH-level boundary tree, one level per
// pipeline stage, and the reached leaf selects a NUM_RULE-bit rule bitmap.
// Boundaries and bitmaps are double-banked: software fills the shadow bank
// while lookups run on the active bank, then swaps them with cfg_commit.
// Optional feature macro: PRIO_ENC_EN adds a registered lowest-rule priority
// encoder stage (out_hit / out_rule_id) and one cycle of latency.
module prog_range_match_tree #(
  parameter int unsigned KEY_W     = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NUM_RULE  = 8,
  parameter int unsigned RULE_ID_W = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [KEY_W-1:0]     in_key,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [DEPTH-1:0]     cfg_addr,
  input  logic [KEY_W-1:0]     cfg_data,
  input  logic                 cfg_commit,
  output logic                 cfg_bank,
  output logic                 out_valid,
  output logic [DEPTH-1:0]     out_leaf,
  output logic [NUM_RULE-1:0]  out_rules
`ifdef PRIO_ENC_EN
  ,
  output logic                 out_hit,
  output logic [RULE_ID_W-1:0] out_rule_id
`endif
);

  localparam int unsigned NODES = 32'd1 << DEPTH;

  // Parameter sanity: bitmaps travel on cfg_data and rule ids must span every rule.
  if (NUM_RULE > KEY_W || (32'd1 << RULE_ID_W) < NUM_RULE) begin : g_bad_params
  end

  // Double-banked storage; node index 0 is never addressed by the tree.
  logic [KEY_W-1:0]    node_q [2][NODES];
  logic [NUM_RULE-1:0] leaf_q [2][NODES];
  logic                bank_q;
  logic                bank_d;
  logic                shadow;

  // Lookup pipeline: stage 0 is the input register, stage l+1 holds level l's decision.
  logic                s_valid_q [DEPTH+1];
  logic                s_valid_d [DEPTH+1];
  logic [KEY_W-1:0]    s_key_q   [DEPTH];
  logic [KEY_W-1:0]    s_key_d   [DEPTH];
  logic [DEPTH-1:0]    s_idx_q   [DEPTH+1];
  logic [DEPTH-1:0]    s_idx_d   [DEPTH+1];
  logic                s_bank_q  [DEPTH+1];
  logic                s_bank_d  [DEPTH+1];

  // Leaf-read stage and first output stage.
  logic                lr_valid_q;
  logic [DEPTH-1:0]    lr_leaf_q;
  logic [NUM_RULE-1:0] lr_rules_q;
  logic [NUM_RULE-1:0] lr_rules_d;
  logic                o_valid_q;
  logic [DEPTH-1:0]    o_leaf_q;
  logic [NUM_RULE-1:0] o_rules_q;

  assign shadow = ~bank_q;

  // Commit toggles the active bank at the sampling edge.
  always_comb begin
    bank_d = bank_q ^ cfg_commit;
  end

  // Bank storage: writes always land in the bank that is shadow before this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int n = 0; n < int'(NODES); n++) begin
          node_q[1'(b)][DEPTH'(n)] <= '0;
          leaf_q[1'(b)][DEPTH'(n)] <= '0;
        end
      end
    end else begin
      bank_q <= bank_d;
      if (cfg_we) begin
        if (cfg_sel) begin
          leaf_q[shadow][cfg_addr] <= cfg_data[NUM_RULE-1:0];
        end else if (cfg_addr != '0) begin
          node_q[shadow][cfg_addr] <= cfg_data;
        end
      end
    end
  end

  // Per-level compare: key >= boundary steps right and appends a 1 to the index.
  always_comb begin
    s_valid_d[0] = in_valid;
    s_key_d[0]   = in_key;
    s_idx_d[0]   = '0;
    s_bank_d[0]  = bank_q;
    for (int l = 0; l < int'(DEPTH); l++) begin
      s_valid_d[l+1] = s_valid_q[l];
      s_bank_d[l+1]  = s_bank_q[l];
      s_idx_d[l+1]   = (s_idx_q[l] << 1)
                     | DEPTH'(s_key_q[l] >= node_q[s_bank_q[l]][DEPTH'(32'd1 << l) | s_idx_q[l]]);
    end
    for (int l = 1; l < int'(DEPTH); l++) begin
      s_key_d[l] = s_key_q[l-1];
    end
  end

  // Pipeline registers; payload only moves with a valid lookup so idle stages stay quiet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= int'(DEPTH); i++) begin
        s_valid_q[i] <= 1'b0;
        s_idx_q[i]   <= '0;
        s_bank_q[i]  <= 1'b0;
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        s_key_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i <= int'(DEPTH); i++) begin
        s_valid_q[i] <= s_valid_d[i];
        if (s_valid_d[i]) begin
          s_idx_q[i]  <= s_idx_d[i];
          s_bank_q[i] <= s_bank_d[i];
        end
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (s_valid_d[i]) begin
          s_key_q[i] <= s_key_d[i];
        end
      end
    end
  end

  // Leaf bitmap read from the bank the lookup was tagged with.
  always_comb begin
    lr_rules_d = leaf_q[s_bank_q[DEPTH]][s_idx_q[DEPTH]];
  end

  // Leaf-read stage, then output stage that forces payload to 0 when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lr_valid_q <= 1'b0;
      lr_leaf_q  <= '0;
      lr_rules_q <= '0;
      o_valid_q  <= 1'b0;
      o_leaf_q   <= '0;
      o_rules_q  <= '0;
    end else begin
      lr_valid_q <= s_valid_q[DEPTH];
      if (s_valid_q[DEPTH]) begin
        lr_leaf_q  <= s_idx_q[DEPTH];
        lr_rules_q <= lr_rules_d;
      end
      o_valid_q <= lr_valid_q;
      o_leaf_q  <= lr_valid_q ? lr_leaf_q  : '0;
      o_rules_q <= lr_valid_q ? lr_rules_q : '0;
    end
  end

  assign cfg_bank = bank_q;

`ifdef PRIO_ENC_EN
  logic                 p_valid_q;
  logic [DEPTH-1:0]     p_leaf_q;
  logic [NUM_RULE-1:0]  p_rules_q;
  logic                 p_hit_q;
  logic [RULE_ID_W-1:0] p_id_q;
  logic [RULE_ID_W-1:0] p_id_d;

  // Lowest-index set rule; scanning downward lets the lowest bit win.
  always_comb begin
    p_id_d = '0;
    for (int r = int'(NUM_RULE) - 1; r >= 0; r--) begin
      if (o_rules_q[r]) begin
        p_id_d = RULE_ID_W'(r);
      end
    end
  end

  // Priority stage; upstream payload is already 0 when idle, so results stay 0 too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_valid_q <= 1'b0;
      p_leaf_q  <= '0;
      p_rules_q <= '0;
      p_hit_q   <= 1'b0;
      p_id_q    <= '0;
    end else begin
      p_valid_q <= o_valid_q;
      p_leaf_q  <= o_leaf_q;
      p_rules_q <= o_rules_q;
      p_hit_q   <= |o_rules_q;
      p_id_q    <= p_id_d;
    end
  end

  assign out_valid   = p_valid_q;
  assign out_leaf    = p_leaf_q;
  assign out_rules   = p_rules_q;
  assign out_hit     = p_hit_q;
  assign out_rule_id = p_id_q;
`else
  assign out_valid = o_valid_q;
  assign out_leaf  = o_leaf_q;
  assign out_rules = o_rules_q;
`endif

endmodule

// File: tb/tb_prog_range_match_tree.sv
// Bench for prog_range_match_tree: directed scenarios plus randomized rounds,
// checked every cycle against a bank-level model where the reached leaf is the
// count of programmed boundaries that are <= key.
module tb_prog_range_match_tree;

  localparam int unsigned KEY_W     = 32;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned NUM_RULE  = 8;
  localparam int unsigned RULE_ID_W = 3;
  localparam int unsigned NLEAF     = 16;
`ifdef PRIO_ENC_EN
  localparam int LAT = DEPTH + 3;
`else
  localparam int LAT = DEPTH + 2;
`endif

  logic                clk;
  logic                reset_n;
  logic                in_valid;
  logic [KEY_W-1:0]    in_key;
  logic                cfg_we;
  logic                cfg_sel;
  logic [DEPTH-1:0]    cfg_addr;
  logic [KEY_W-1:0]    cfg_data;
  logic                cfg_commit;
  logic                cfg_bank;
  logic                out_valid;
  logic [DEPTH-1:0]    out_leaf;
  logic [NUM_RULE-1:0] out_rules;
`ifdef PRIO_ENC_EN
  logic                 out_hit;
  logic [RULE_ID_W-1:0] out_rule_id;
`endif

  prog_range_match_tree #(
    .KEY_W(KEY_W), .DEPTH(DEPTH), .NUM_RULE(NUM_RULE), .RULE_ID_W(RULE_ID_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_key(in_key),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_bank(cfg_bank), .out_valid(out_valid),
    .out_leaf(out_leaf), .out_rules(out_rules)
`ifdef PRIO_ENC_EN
    , .out_hit(out_hit), .out_rule_id(out_rule_id)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                v;
    logic [DEPTH-1:0]    leaf;
    logic [NUM_RULE-1:0] rules;
  } exp_t;

  exp_t           expq[$];
  logic [31:0]    mbnd  [2][NLEAF];
  logic [7:0]     mrule [2][NLEAF];
  logic           mb;
  int             checks;
  int             errors;

  logic [31:0]    pv [15];
  logic [7:0]     pl [NLEAF];
  logic [31:0]    bk_key [10];
  logic           bk_com [10];
  logic [3:0]     bk_leaf [10];
  logic [7:0]     bk_rules [10];
  int             bn;

  // Range semantics: leaf = number of boundaries not greater than the key.
  function automatic int ref_leaf(input logic b, input logic [31:0] key);
    int n = 0;
    for (int a = 1; a < int'(NLEAF); a++) if (key >= mbnd[b][a]) n++;
    return n;
  endfunction

  function automatic int low_bit(input logic [7:0] r);
    int id = 0;
    for (int i = 7; i >= 0; i--) if (r[i]) id = i;
    return id;
  endfunction

  // Heap address of the p-th boundary in sorted (in-order) position.
  function automatic logic [3:0] inorder(input int p);
    int q = p + 1;
    int tz = 0;
    while (((q >> tz) & 1) == 0) tz++;
    return 4'((1 << (int'(DEPTH) - 1 - tz)) + (q >> (tz + 1)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rkey();
    logic [31:0] b;
    if ($urandom_range(0, 1) == 0) return $urandom;
    b = mbnd[mb][$urandom_range(1, 15)];
    return b - 32'($urandom_range(0, 1));
  endfunction

  // One clock: drive, update the model at the edge, then compare outputs.
  task automatic step(input logic v, input logic [31:0] key, input logic we,
                      input logic sel, input logic [3:0] addr,
                      input logic [31:0] data, input logic commit);
    exp_t e;
    exp_t cur;
    in_valid = v; in_key = key; cfg_we = we; cfg_sel = sel;
    cfg_addr = addr; cfg_data = data; cfg_commit = commit;
    @(posedge clk);
    cur = '{1'b0, 4'd0, 8'd0};
    if (reset_n) begin
      e.v     = v;
      e.leaf  = v ? 4'(ref_leaf(mb, key)) : 4'd0;
      e.rules = v ? mrule[mb][e.leaf] : 8'd0;
      if (expq.size() == LAT) cur = expq.pop_front();
      expq.push_back(e);
      if (we) begin
        if (sel) mrule[~mb][addr] = data[7:0];
        else if (addr != 4'd0) mbnd[~mb][addr] = data;
      end
      if (commit) mb = ~mb;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(cur.v));
    chk("out_leaf",  32'(out_leaf),  32'(cur.leaf));
    chk("out_rules", 32'(out_rules), 32'(cur.rules));
    chk("cfg_bank",  32'(cfg_bank),  32'(mb));
`ifdef PRIO_ENC_EN
    chk("out_hit",     32'(out_hit),     32'(cur.rules != 8'd0));
    chk("out_rule_id", 32'(out_rule_id), 32'(low_bit(cur.rules)));
`endif
    in_valid = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  // Issue bn lookups back to back and check each result against literal values.
  task automatic burst(input string tag);
    for (int i = 0; i < bn + LAT; i++) begin
      if (i < bn) step(1'b1, bk_key[i], 1'b0, 1'b0, 4'd0, 32'd0, bk_com[i]);
      else        step(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
      if (i >= LAT) begin
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_leaf"},  32'(out_leaf),  32'(bk_leaf[i-LAT]));
        chk({tag, "_rules"}, 32'(out_rules), 32'(bk_rules[i-LAT]));
`ifdef PRIO_ENC_EN
        chk({tag, "_hit"}, 32'(out_hit), 32'(bk_rules[i-LAT] != 8'd0));
        chk({tag, "_id"},  32'(out_rule_id), 32'(low_bit(bk_rules[i-LAT])));
`endif
      end
    end
  endtask

  // Write pv/pl into the shadow bank (plus one ignored node-0 write).
  task automatic program_shadow(input bit lk);
    for (int p = 0; p < 15; p++)
      step(lk ? 1'($urandom_range(0, 1)) : 1'b0, rkey(), 1'b1, 1'b0, inorder(p), pv[p], 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 4'd0, $urandom, 1'b0);
    for (int j = 0; j < int'(NLEAF); j++)
      step(lk ? 1'($urandom_range(0, 1)) : 1'b0, rkey(), 1'b1, 1'b1, 4'(j), {24'd0, pl[j]}, 1'b0);
  endtask

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < int'(NLEAF); a++) begin
        mbnd[b][a] = 32'd0; mrule[b][a] = 8'd0;
      end
    mb = 1'b0;
    expq.delete();
  endtask

  task automatic slice_prog(input logic [7:0] fill, input bit use_fill);
    for (int p = 0; p < 15; p++) pv[p] = 32'(p + 1) << 28;
    for (int j = 0; j < int'(NLEAF); j++) pl[j] = use_fill ? fill : 8'(1 << (j % 8));
  endtask

  initial begin
    logic [31:0] t;
    checks = 0; errors = 0;
    in_valid = 1'b0; in_key = '0; cfg_we = 1'b0; cfg_sel = 1'b0;
    cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
    reset_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_leaf",  32'(out_leaf),  32'd0);
    chk("rst_rules", 32'(out_rules), 32'd0);
    chk("rst_bank",  32'(cfg_bank),  32'd0);
    reset_n = 1'b1;

    // Unprogrammed banks: every lookup lands on the last leaf with no rules.
    bn = 10;
    for (int i = 0; i < 10; i++) begin
      bk_key[i] = 32'h12345678; bk_com[i] = 1'b0; bk_leaf[i] = 4'd15; bk_rules[i] = 8'h00;
    end
    burst("unprog");
    chk("unprog_bank", 32'(cfg_bank), 32'd0);

    // Slice program: leaf equals key[31:28].
    slice_prog(8'h00, 1'b0);
    program_shadow(1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
    chk("slice_bank", 32'(cfg_bank), 32'd1);
    bn = 1;
    bk_key[0] = 32'hC0A80040; bk_com[0] = 1'b0; bk_leaf[0] = 4'd12; bk_rules[0] = 8'h10;
    burst("slice");

    // Extremes and equality-goes-right.
    bn = 4;
    bk_key[0] = 32'h00000000; bk_leaf[0] = 4'd0;  bk_rules[0] = 8'h01;
    bk_key[1] = 32'hFFFFFFFF; bk_leaf[1] = 4'd15; bk_rules[1] = 8'h80;
    bk_key[2] = 32'h7FFFFFFF; bk_leaf[2] = 4'd7;  bk_rules[2] = 8'h80;
    bk_key[3] = 32'h80000000; bk_leaf[3] = 4'd8;  bk_rules[3] = 8'h01;
    for (int i = 0; i < 4; i++) bk_com[i] = 1'b0;
    burst("b2b");

    // Bank swap around a commit edge.
    slice_prog(8'hFF, 1'b1);
    program_shadow(1'b0);
    bn = 3;
    for (int i = 0; i < 3; i++) begin
      bk_key[i] = 32'h50000000; bk_leaf[i] = 4'd5; bk_com[i] = (i == 1);
    end
    bk_rules[0] = 8'h20; bk_rules[1] = 8'h20; bk_rules[2] = 8'hFF;
    burst("swap");
    chk("swap_bank", 32'(cfg_bank), 32'd0);

    // Write coincident with commit lands in the bank that becomes active.
    step(1'b0, 32'd0, 1'b1, 1'b1, 4'd3, 32'h0000000A, 1'b1);
    chk("coinc_bank", 32'(cfg_bank), 32'd1);
    bn = 1;
    bk_key[0] = 32'h30000000; bk_com[0] = 1'b0; bk_leaf[0] = 4'd3; bk_rules[0] = 8'h0A;
    burst("coinc");

    // Reset with lookups in flight: all dropped, both banks cleared.
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_bank",  32'(cfg_bank),  32'd0);
    model_clear();
    idle(1);
    reset_n = 1'b1;
    idle(LAT + 2);
    bn = 1;
    bk_key[0] = 32'h12345678; bk_com[0] = 1'b0; bk_leaf[0] = 4'd15; bk_rules[0] = 8'h00;
    burst("clr_bank0");
    step(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
    bk_key[0] = 32'h00000000;
    burst("clr_bank1");

    // Randomized rounds: sorted random boundaries, random bitmaps, random traffic.
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 15; a++) pv[a] = $urandom;
      for (int a = 0; a < 14; a++)
        for (int c = 0; c < 14 - a; c++)
          if (pv[c] > pv[c+1]) begin t = pv[c]; pv[c] = pv[c+1]; pv[c+1] = t; end
      if (r % 2 == 1) pv[7] = pv[6];
      for (int j = 0; j < int'(NLEAF); j++) pl[j] = 8'($urandom);
      program_shadow(1'b1);
      step(1'($urandom_range(0, 1)), rkey(), 1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
      repeat (60) step(1'($urandom_range(0, 1)), rkey(), 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
    end
    idle(LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
